lcd_spi_sink: RTL and testbench
===============================

// Module: lcd_spi_sink
// PURPOSE
//  SPI display-slave receiver: the far end of the LCD SPI link our lcd_video master drives.
//  Oversamples csn/clk/mosi/dc/resn in the system clock and decodes ST7789-style
//  CASET/RASET/RAMWR traffic into a stream of (x, y, color) pixel writes.
//  Used as a bench display model and as an on-FPGA framebuffer feeder.
// PARAMETERS
//  c_x_bits        8  width of px_x (low bits of the 16-bit CASET values)
//  c_y_bits        8  width of px_y (low bits of the 16-bit RASET values)
//  c_clk_polarity  1  SPI clock idle level; data is sampled on the clock edge leaving idle
//  c_sync_stages   2  synchronizer flops per SPI input (>=2)
// PORTS
//  clk        in   1         system clock; SPI clock rate must be <= clk/4
//  resetn     in   1         asynchronous reset, active low
//  spi_csn    in   1         chip select, active low
//  spi_clk    in   1         SPI clock
//  spi_mosi   in   1         serial data, MSB first
//  spi_dc     in   1         0 = command byte, 1 = data byte
//  spi_resn   in   1         display reset from the master, active low
//  cmd_valid  out  1         1-cycle pulse per received command byte
//  cmd        out  8         last command byte
//  px_valid   out  1         1-cycle pulse per completed pixel
//  px_x       out  c_x_bits  pixel column
//  px_y       out  c_y_bits  pixel row
//  px_color   out  16        RGB565 pixel, first byte = [15:8]
// BEHAVIOUR
//  - resetn=0: all outputs 0; state IDLE; bit count 0; window xs=ys=0, xe/ye all ones.
//  - Synchronized spi_resn=0 has the same effect, applied synchronously.
//  - Sample edge = synchronized spi_clk transition away from c_clk_polarity while csn=0.
//  - At each sample edge: shift mosi into the byte register; the 8th edge completes the byte.
//  - dc is taken at the 8th edge. csn high between bytes is allowed.
//  - csn rising mid-byte discards only the partial bits. FSM state, byte index and any
//    pending pixel half are kept.
//  - Command byte (dc=0): pulse cmd_valid and load cmd. A pending pixel half is dropped.
//    Next state: 0x2A CASET, 0x2B RASET, 0x2C RAMWR (pointer x=xs, y=ys), others SKIP.
//  - CASET: data bytes 0..3 = xs[15:8], xs[7:0], xe[15:8], xe[7:0].
//    Bytes beyond 3 are ignored. Values are truncated to c_x_bits.
//  - RASET: the same, for ys/ye truncated to c_y_bits.
//  - Window registers update only when their byte arrives. A partial CASET keeps the
//    already-written bytes.
//  - RAMWR: even data byte -> color[15:8]; odd data byte -> color[7:0].
//    On the odd byte, px_valid pulses with the current x/y/color.
//    Then: if x==xe, x<=xs and y advances (y==ye ? ys : y+1); else x<=x+1 (mod 2^c_x_bits).
//    So xs>xe wraps through 0. Writing past the window restarts at (xs,ys).
//  - SKIP: data bytes are ignored.
//  - Latency: px_valid/cmd_valid occur a fixed c_sync_stages+2 clk cycles after the pad edge of
//    the last bit. px_x/px_y/px_color hold until the next px_valid.
//  - A byte completing in the same cycle as an spi_resn assertion is discarded.
// TESTING
//  1 reset: resetn=0 with random SPI activity -> all outputs 0.
//    After release, first RAMWR pixel lands at (0,0).
//  2 CASET 00 00 00 03, RASET 00 00 00 01, RAMWR + 8 pixels 0x0001..0x0008 -> (0,0)..(3,0)
//    then (0,1)..(3,1), colors in order. A 9th pixel wraps to (0,0).
//  3 RAMWR, pixel byte F8, new cmd 0x2C, bytes 07 E0 -> one px_valid at (xs,ys) with 0x07E0;
//    the orphan F8 produces no pixel.
//  4 csn high after 5 bits of a byte, then a full byte 0xA5 (dc=1) in RAMWR ->
//    byte taken as A5 (bits realigned).
//  5 cmd 0x36 + data 0x60 -> cmd_valid once with cmd=0x36; no px_valid; window unchanged.
//  6 spi_resn low mid-RAMWR, then RAMWR + 1 pixel without CASET/RASET ->
//    pixel at (0,0); check latency is constant across SPI rates clk/4..clk/32.

Source files
------------

// File: rtl/lcd_spi_sink.sv
// SPI display-slave receiver: oversamples the SPI pins in the system clock and decodes
// CASET/RASET/RAMWR traffic into (x, y, RGB565) pixel writes.
module lcd_spi_sink #(
  parameter int c_x_bits       = 8,
  parameter int c_y_bits       = 8,
  parameter bit c_clk_polarity = 1'b1,
  parameter int c_sync_stages  = 2
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                spi_csn,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic                spi_dc,
  input  logic                spi_resn,
  output logic                cmd_valid,
  output logic [7:0]          cmd,
  output logic                px_valid,
  output logic [c_x_bits-1:0] px_x,
  output logic [c_y_bits-1:0] px_y,
  output logic [15:0]         px_color,
  output logic [2:0]          dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CASET = 3'd1,
    S_RASET = 3'd2,
    S_RAMWR = 3'd3,
    S_SKIP  = 3'd4
  } state_t;

  // Pad order {csn, clk, mosi, dc, resn}; reset value is the idle bus.
  localparam logic [4:0] c_pad_idle = {1'b1, c_clk_polarity, 1'b0, 1'b0, 1'b1};

  logic [4:0]          r_sync [c_sync_stages];
  logic                w_csn_s, w_clk_s, w_mosi_s, w_dc_s, w_resn_s;
  logic                r_clk_d;
  logic                w_sample;
  logic [7:0]          r_shift;
  logic [2:0]          r_bitcnt;
  logic                r_byte_done;
  logic                r_byte_dc;
  state_t              r_state, w_next_state;
  logic [2:0]          r_idx;
  logic [15:0]         r_xs, r_xe, r_ys, r_ye;
  logic [c_x_bits-1:0] w_xs, w_xe, r_x;
  logic [c_y_bits-1:0] w_ys, w_ye, r_y;
  logic [7:0]          r_color_hi;
  logic                w_unused;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < c_sync_stages; i++) r_sync[i] <= c_pad_idle;
    end else begin
      r_sync[0] <= {spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn};
      for (int i = 1; i < c_sync_stages; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign {w_csn_s, w_clk_s, w_mosi_s, w_dc_s, w_resn_s} = r_sync[c_sync_stages-1];
  assign w_sample = (w_clk_s != c_clk_polarity) && (r_clk_d == c_clk_polarity) && !w_csn_s;

  assign w_xs = r_xs[c_x_bits-1:0];
  assign w_xe = r_xe[c_x_bits-1:0];
  assign w_ys = r_ys[c_y_bits-1:0];
  assign w_ye = r_ye[c_y_bits-1:0];
  // Window registers keep full 16-bit CASET/RASET values; only the low bits are used.
  assign w_unused = ^{r_xs, r_xe, r_ys, r_ye};
  assign dbg_state = r_state;

  // Byte assembly: csn high only drops the partial bit count, nothing else.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_clk_d     <= c_clk_polarity;
      r_shift     <= 8'h00;
      r_bitcnt    <= 3'd0;
      r_byte_done <= 1'b0;
      r_byte_dc   <= 1'b0;
    end else begin
      r_clk_d     <= w_clk_s;
      r_byte_done <= 1'b0;
      if (!w_resn_s) begin
        r_shift   <= 8'h00;
        r_bitcnt  <= 3'd0;
        r_byte_dc <= 1'b0;
      end else if (w_csn_s) begin
        r_bitcnt <= 3'd0;
      end else if (w_sample) begin
        r_shift  <= {r_shift[6:0], w_mosi_s};
        r_bitcnt <= r_bitcnt + 3'd1;
        if (r_bitcnt == 3'd7) begin
          r_byte_done <= 1'b1;
          r_byte_dc   <= w_dc_s;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= S_IDLE;
    else         r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (r_byte_done && !r_byte_dc) begin
      case (r_shift)
        8'h2A:   w_next_state = S_CASET;
        8'h2B:   w_next_state = S_RASET;
        8'h2C:   w_next_state = S_RAMWR;
        default: w_next_state = S_SKIP;
      endcase
    end
    if (!w_resn_s) w_next_state = S_IDLE;
  end

  // cmd_valid/px_valid are single-cycle valid strobes with no ready: the consumer must
  // take the qualified outputs in the cycle the strobe is high.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_idx      <= 3'd0;
      r_xs       <= 16'h0000;
      r_xe       <= 16'hFFFF;
      r_ys       <= 16'h0000;
      r_ye       <= 16'hFFFF;
      r_x        <= '0;
      r_y        <= '0;
      r_color_hi <= 8'h00;
      cmd_valid  <= 1'b0;
      cmd        <= 8'h00;
      px_valid   <= 1'b0;
      px_x       <= '0;
      px_y       <= '0;
      px_color   <= 16'h0000;
    end else begin
      cmd_valid <= 1'b0;
      px_valid  <= 1'b0;
      if (!w_resn_s) begin
        r_idx      <= 3'd0;
        r_xs       <= 16'h0000;
        r_xe       <= 16'hFFFF;
        r_ys       <= 16'h0000;
        r_ye       <= 16'hFFFF;
        r_x        <= '0;
        r_y        <= '0;
        r_color_hi <= 8'h00;
        cmd        <= 8'h00;
        px_x       <= '0;
        px_y       <= '0;
        px_color   <= 16'h0000;
      end else if (r_byte_done && !r_byte_dc) begin
        cmd_valid <= 1'b1;
        cmd       <= r_shift;
        r_idx     <= 3'd0;
        if (r_shift == 8'h2C) begin
          r_x <= w_xs;
          r_y <= w_ys;
        end
      end else if (r_byte_done) begin
        case (r_state)
          S_CASET, S_RASET: begin
            if (r_idx != 3'd4) begin
              r_idx <= r_idx + 3'd1;
              if (r_state == S_CASET) begin
                case (r_idx[1:0])
                  2'd0:    r_xs[15:8] <= r_shift;
                  2'd1:    r_xs[7:0]  <= r_shift;
                  2'd2:    r_xe[15:8] <= r_shift;
                  default: r_xe[7:0]  <= r_shift;
                endcase
              end else begin
                case (r_idx[1:0])
                  2'd0:    r_ys[15:8] <= r_shift;
                  2'd1:    r_ys[7:0]  <= r_shift;
                  2'd2:    r_ye[15:8] <= r_shift;
                  default: r_ye[7:0]  <= r_shift;
                endcase
              end
            end
          end
          S_RAMWR: begin
            r_idx <= {2'b00, ~r_idx[0]};
            if (!r_idx[0]) begin
              r_color_hi <= r_shift;
            end else begin
              px_valid <= 1'b1;
              px_x     <= r_x;
              px_y     <= r_y;
              px_color <= {r_color_hi, r_shift};
              if (r_x == w_xe) begin
                r_x <= w_xs;
                r_y <= (r_y == w_ye) ? w_ys : r_y + c_y_bits'(1);
              end else begin
                r_x <= r_x + c_x_bits'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lcd_spi_sink.sv
// Directed bench for lcd_spi_sink: bit-banged SPI master, pixel expectation tables,
// and hand-written sequences for aborts, orphan halves, display reset and latency.
module tb_lcd_spi_sink;

  localparam int SYNC = 2;
  localparam int LAT  = SYNC + 2;

  logic        clk, resetn;
  logic        spi_csn, spi_clk, spi_mosi, spi_dc, spi_resn;
  logic        cmd_valid, px_valid;
  logic [7:0]  cmd, px_x, px_y;
  logic [15:0] px_color;
  logic [2:0]  dbg_state;

  lcd_spi_sink #(
    .c_x_bits(8), .c_y_bits(8), .c_clk_polarity(1'b1), .c_sync_stages(SYNC)
  ) dut (
    .clk(clk), .resetn(resetn),
    .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_dc(spi_dc), .spi_resn(spi_resn),
    .cmd_valid(cmd_valid), .cmd(cmd),
    .px_valid(px_valid), .px_x(px_x), .px_y(px_y), .px_color(px_color),
    .dbg_state(dbg_state)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // monitor
  int          px_cnt = 0, cmd_cnt = 0;
  int          last_px_cyc = 0, last_cmd_cyc = 0;
  logic [7:0]  last_x = 0, last_y = 0, last_cmd = 0;
  logic [15:0] last_color = 0;
  always @(negedge clk) begin
    if (px_valid) begin
      px_cnt++;
      last_x = px_x; last_y = px_y; last_color = px_color;
      last_px_cyc = cyc;
    end
    if (cmd_valid) begin
      cmd_cnt++;
      last_cmd = cmd;
      last_cmd_cyc = cyc;
    end
  end

  // scoreboard
  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // driver tasks
  int cur_half = 2;
  int t_last = 0;

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic dc, input int nbits);
    if (spi_csn) begin
      spi_csn = 1'b0;
      wait_cyc(cur_half);
    end
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = b[7-i];
      spi_dc   = dc;
      wait_cyc(cur_half);
      spi_clk = 1'b0;
      t_last  = cyc;
      wait_cyc(cur_half);
      spi_clk = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    spi_bits(b, dc, 8);
  endtask

  task automatic send_cmd4(input logic [7:0] c, input logic [31:0] d);
    send(c, 1'b0);
    for (int i = 3; i >= 0; i--) send(d[8*i +: 8], 1'b1);
  endtask

  task automatic pixel(input string name, input logic [15:0] c, input logic [7:0] ex,
                       input logic [7:0] ey);
    int n0;
    logic [31:0] e;
    n0 = px_cnt;
    exp_q.push_back({ex, ey, c});
    send(c[15:8], 1'b1);
    send(c[7:0], 1'b1);
    wait_cyc(LAT + 4);
    e = exp_q.pop_front();
    check($sformatf("%s count", name), 48'(px_cnt - n0), 48'd1);
    check($sformatf("%s pixel", name), {16'h0, last_x, last_y, last_color}, {16'h0, e});
  endtask

  typedef struct {
    logic [15:0] color;
    logic [7:0]  x;
    logic [7:0]  y;
  } pix_vec_t;

  typedef struct {
    int          half;
    logic [15:0] color;
  } rate_vec_t;

  pix_vec_t  tbl[14];
  rate_vec_t rates[4];

  initial begin
    int n0, c0;

    for (int i = 0; i < 9; i++) begin
      tbl[i].color = 16'(i + 1);
      tbl[i].x     = 8'(i % 4);
      tbl[i].y     = (i == 8) ? 8'd0 : 8'(i / 4);
    end
    tbl[9]  = '{16'hC001, 8'hFE, 8'd5};
    tbl[10] = '{16'hC002, 8'hFF, 8'd5};
    tbl[11] = '{16'hC003, 8'h00, 8'd5};
    tbl[12] = '{16'hC004, 8'h01, 8'd5};
    tbl[13] = '{16'hC005, 8'hFE, 8'd5};
    rates[0] = '{2,  16'h1111};
    rates[1] = '{4,  16'h2222};
    rates[2] = '{8,  16'h4444};
    rates[3] = '{16, 16'h8888};

    // 1: reset with random SPI activity
    resetn = 1'b0; spi_csn = 1'b1; spi_clk = 1'b1; spi_mosi = 1'b0;
    spi_dc = 1'b0; spi_resn = 1'b1;
    for (int i = 0; i < 40; i++) begin
      spi_csn  = 1'($urandom_range(0, 1));
      spi_clk  = 1'($urandom_range(0, 1));
      spi_mosi = 1'($urandom_range(0, 1));
      spi_dc   = 1'($urandom_range(0, 1));
      spi_resn = 1'($urandom_range(0, 1));
      wait_cyc(1);
      if (i % 8 == 7)
        check("reset outputs", {6'h0, cmd_valid, cmd, px_valid, px_x, px_y, px_color}, 48'h0);
    end
    spi_csn = 1'b1; spi_clk = 1'b1; spi_resn = 1'b1;
    wait_cyc(4);
    resetn = 1'b1;
    wait_cyc(6);
    c0 = cmd_cnt;
    send(8'h2C, 1'b0);
    wait_cyc(LAT + 2);
    check("first cmd count", 48'(cmd_cnt - c0), 48'd1);
    check("first cmd value", 48'(last_cmd), 48'h2C);
    check("cmd latency", 48'(last_cmd_cyc - t_last), 48'(LAT));
    pixel("post-reset", 16'h1234, 8'd0, 8'd0);

    // 2: 4x2 window with wrap back to origin
    send_cmd4(8'h2A, 32'h0000_0003);
    send_cmd4(8'h2B, 32'h0000_0001);
    send(8'h2C, 1'b0);
    for (int i = 0; i < 9; i++)
      pixel($sformatf("window px%0d", i), tbl[i].color, tbl[i].x, tbl[i].y);

    // 3: orphan high byte dropped by a new command
    send(8'h2C, 1'b0);
    n0 = px_cnt;
    send(8'hF8, 1'b1);
    send(8'h2C, 1'b0);
    wait_cyc(LAT + 4);
    check("orphan no pixel", 48'(px_cnt - n0), 48'd0);
    pixel("orphan restart", 16'h07E0, 8'd0, 8'd0);

    // 4: csn abort after 5 bits realigns the next byte
    send(8'h2C, 1'b0);
    spi_bits(8'hFF, 1'b1, 5);
    spi_csn = 1'b1;
    wait_cyc(6);
    pixel("csn abort", 16'hA53C, 8'd0, 8'd0);

    // 5: unknown command skips its data, window untouched
    c0 = cmd_cnt; n0 = px_cnt;
    send(8'h36, 1'b0);
    send(8'h60, 1'b1);
    spi_csn = 1'b1;
    wait_cyc(LAT + 4);
    check("skip cmd count", 48'(cmd_cnt - c0), 48'd1);
    check("skip cmd value", 48'(last_cmd), 48'h36);
    check("skip no pixel", 48'(px_cnt - n0), 48'd0);
    send(8'h2C, 1'b0);
    for (int i = 0; i < 5; i++)
      pixel($sformatf("after skip px%0d", i), 16'h5000 + 16'(i),
            (i < 4) ? 8'(i) : 8'd0, (i < 4) ? 8'd0 : 8'd1);

    // partial CASET keeps xe
    send(8'h2A, 1'b0);
    send(8'h00, 1'b1);
    send(8'h02, 1'b1);
    send(8'h2C, 1'b0);
    pixel("partial caset a", 16'h6001, 8'd2, 8'd0);
    pixel("partial caset b", 16'h6002, 8'd3, 8'd0);
    pixel("partial caset c", 16'h6003, 8'd2, 8'd1);

    // xs > xe wraps through 0; single-row window wraps y to ys
    send_cmd4(8'h2A, 32'h00FE_0001);
    send_cmd4(8'h2B, 32'h0005_0005);
    send(8'h2C, 1'b0);
    for (int i = 9; i < 14; i++)
      pixel($sformatf("wrap px%0d", i - 9), tbl[i].color, tbl[i].x, tbl[i].y);

    // 6: display reset mid-RAMWR, then latency across SPI rates
    send(8'h2C, 1'b0);
    send(8'hF8, 1'b1);
    spi_resn = 1'b0;
    wait_cyc(SYNC + 4);
    check("spi_resn outputs", {6'h0, cmd_valid, cmd, px_valid, px_x, px_y, px_color}, 48'h0);
    spi_resn = 1'b1;
    spi_csn  = 1'b1;
    wait_cyc(SYNC + 4);
    for (int r = 0; r < 4; r++) begin
      cur_half = rates[r].half;
      send(8'h2C, 1'b0);
      wait_cyc(LAT + 2);
      check($sformatf("cmd latency half=%0d", cur_half), 48'(last_cmd_cyc - t_last), 48'(LAT));
      pixel($sformatf("rate half=%0d", cur_half), rates[r].color, 8'd0, 8'd0);
      check($sformatf("px latency half=%0d", cur_half), 48'(last_px_cyc - t_last), 48'(LAT));
      spi_csn = 1'b1;
      wait_cyc(4);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
